// File: rtl/display_scan_mux_if.sv
// Display scanner bus: value/dp load side and the digit drive side.
// master drives value_in/load/dp_in/digit_en; slave drives nibble_out/an/dp_n/frame_tick.
interface display_scan_mux_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] value_in;
  logic                  load;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   digit_en;
  logic [3:0]            nibble_out;
  logic [N_DIGITS-1:0]   an;
  logic                  dp_n;
  logic                  frame_tick;

  modport master (
    output value_in, load, dp_in, digit_en,
    input  nibble_out, an, dp_n, frame_tick
  );

  modport slave (
    input  value_in, load, dp_in, digit_en,
    output nibble_out, an, dp_n, frame_tick
  );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scanner with frame-synchronous value update.
// Ports: clk, rst (async, active-high), bus (slave: value/dp load in, anode/nibble/dp out).
module display_scan_mux #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16,
  parameter int LZ_BLANK    = 1
) (
  input logic               clk,
  input logic               rst,
  display_scan_mux_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IMAX = IW'(N_DIGITS - 1);

  logic [PW-1:0]       presc, presc_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [VW-1:0]       disp_val, disp_val_nxt, pend_val;
  logic [N_DIGITS-1:0] disp_dp, disp_dp_nxt, pend_dp;
  logic                pending;
  logic                wrap, frame;
  logic [N_DIGITS-1:0] keep;
  logic                seen;
  logic                lit;
  logic [N_DIGITS-1:0] an_nxt;
  logic [3:0]          nib_nxt;
  logic                dp_nxt;

  logic [N_DIGITS-1:0] an_q;
  logic [3:0]          nib_q;
  logic                dp_q;
  logic                tick_q;

  always_comb begin
    wrap      = (presc == PMAX);
    frame     = wrap && (idx == IMAX);
    presc_nxt = wrap ? '0 : presc + 1'b1;
    idx_nxt   = idx;
    if (wrap)
      idx_nxt = (idx == IMAX) ? '0 : idx + 1'b1;
  end

  // A load on the boundary edge bypasses the pending regs.
  always_comb begin
    disp_val_nxt = disp_val;
    disp_dp_nxt  = disp_dp;
    if (frame) begin
      if (bus.load) begin
        disp_val_nxt = bus.value_in;
        disp_dp_nxt  = bus.dp_in;
      end else if (pending) begin
        disp_val_nxt = pend_val;
        disp_dp_nxt  = pend_dp;
      end
    end
  end

  // Scan from the top nibble down; once a nonzero nibble is seen,
  // every lower digit is shown. Digit 0 always shows.
  always_comb begin
    seen = 1'b0;
    keep = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (disp_val_nxt[4*i +: 4] != 4'd0);
      keep[i] = seen || (i == 0) || (LZ_BLANK == 0);
    end
  end

  always_comb begin
    lit = (presc_nxt >= DEAD)
       && bus.digit_en[idx_nxt]
       && keep[idx_nxt];
    an_nxt  = lit ? ~(N_DIGITS'(1) << idx_nxt) : '1;
    nib_nxt = disp_val_nxt[{idx_nxt, 2'b00} +: 4];
    dp_nxt  = lit ? ~disp_dp_nxt[idx_nxt] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      idx      <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pending  <= 1'b0;
      an_q     <= '1;
      nib_q    <= '0;
      dp_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      presc    <= presc_nxt;
      idx      <= idx_nxt;
      disp_val <= disp_val_nxt;
      disp_dp  <= disp_dp_nxt;
      if (frame) begin
        pending <= 1'b0;
      end else if (bus.load) begin
        pend_val <= bus.value_in;
        pend_dp  <= bus.dp_in;
        pending  <= 1'b1;
      end
      an_q   <= an_nxt;
      nib_q  <= nib_nxt;
      dp_q   <= dp_nxt;
      tick_q <= frame;
    end
  end

  assign bus.an         = an_q;
  assign bus.nibble_out = nib_q;
  assign bus.dp_n       = dp_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux (8 digits, 4 clk slots, 1 dead cycle).
// Samples on the falling edge; k counts rising edges since reset release.
module tb_display_scan_mux;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   k = 0;

  display_scan_mux_if #(.N_DIGITS(N)) bus ();

  display_scan_mux #(
    .N_DIGITS   (N),
    .REFRESH_DIV(4),
    .DEAD_CYCLES(1),
    .LZ_BLANK   (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic go_to(input int pos);
    for (int i = 0; i < 40 && (k % 32) != pos; i++)
      tick();
    chk("go_to", 32'(k % 32), 32'(pos));
  endtask

  task automatic load_now(input logic [31:0] v, input logic [7:0] dp);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  // Starts at a frame start (idx 0, presc 0); checks the dead cycle and
  // the first active cycle of every slot, then the closing frame_tick.
  task automatic scan_frame(input string tag, input logic [31:0] v,
                            input logic [7:0] lit, input logic [7:0] dp);
    logic [7:0] a;
    for (int s = 0; s < 8; s++) begin
      chk($sformatf("%s dead an s%0d", tag, s), 32'(bus.an), 32'hFF);
      chk($sformatf("%s dead nib s%0d", tag, s),
          32'(bus.nibble_out), 32'((v >> (4*s)) & 32'hF));
      chk($sformatf("%s dead dp s%0d", tag, s), 32'(bus.dp_n), 32'd1);
      tick();
      a = lit[s] ? ~(8'd1 << s) : 8'hFF;
      chk($sformatf("%s an s%0d", tag, s), 32'(bus.an), 32'(a));
      chk($sformatf("%s nib s%0d", tag, s),
          32'(bus.nibble_out), 32'((v >> (4*s)) & 32'hF));
      chk($sformatf("%s dp s%0d", tag, s), 32'(bus.dp_n),
          32'(!(lit[s] && dp[s])));
      chk($sformatf("%s tick s%0d", tag, s), 32'(bus.frame_tick), 32'd0);
      tick();
      tick();
      tick();
    end
    chk($sformatf("%s frame_tick", tag), 32'(bus.frame_tick), 32'd1);
  endtask

  initial begin
    bus.value_in = '0;
    bus.load     = 1'b0;
    bus.dp_in    = '0;
    bus.digit_en = 8'hFF;

    repeat (2) @(negedge clk);
    chk("rst an", 32'(bus.an), 32'hFF);
    chk("rst dp_n", 32'(bus.dp_n), 32'd1);
    chk("rst nib", 32'(bus.nibble_out), 32'd0);
    chk("rst tick", 32'(bus.frame_tick), 32'd0);
    rst = 1'b0;
    k = 0;

    // 1: zero display, only digit 0 lit
    scan_frame("t1", 32'h0, 8'h01, 8'h00);

    // 2: mid-frame load waits for the boundary
    go_to(12);
    load_now(32'h89ABCDEF, 8'h00);
    chk("t2 hold nib", 32'(bus.nibble_out), 32'd0);
    go_to(28);
    chk("t2 hold nib7", 32'(bus.nibble_out), 32'd0);
    chk("t2 hold an7", 32'(bus.an), 32'hFF);
    go_to(0);
    scan_frame("t2", 32'h89ABCDEF, 8'hFF, 8'h00);

    // 3: last load wins; boundary load shows immediately
    go_to(4);
    load_now(32'h11111111, 8'h00);
    go_to(20);
    load_now(32'h22222222, 8'h00);
    go_to(0);
    scan_frame("t3a", 32'h22222222, 8'hFF, 8'h00);
    go_to(31);
    load_now(32'h33333333, 8'h00);
    scan_frame("t3b", 32'h33333333, 8'hFF, 8'h00);

    // 4: leading-zero blanking
    go_to(31);
    load_now(32'h00000A30, 8'h00);
    scan_frame("t4a", 32'h00000A30, 8'h07, 8'h00);
    go_to(31);
    load_now(32'h0, 8'h00);
    scan_frame("t4b", 32'h0, 8'h01, 8'h00);

    // 5: live digit mask and decimal points
    bus.digit_en = 8'h0F;
    go_to(31);
    load_now(32'h89ABCDEF, 8'h22);
    scan_frame("t5", 32'h89ABCDEF, 8'h0F, 8'h22);
    bus.digit_en = 8'hFF;

    // 6: async reset mid-slot discards a pending load
    go_to(21);
    load_now(32'h12345678, 8'hFF);
    chk("t6 pre an", 32'(bus.an), 32'hDF);
    #1 rst = 1'b1;
    #1;
    chk("t6 async an", 32'(bus.an), 32'hFF);
    chk("t6 async nib", 32'(bus.nibble_out), 32'd0);
    chk("t6 async dp", 32'(bus.dp_n), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    scan_frame("t6a", 32'h0, 8'h01, 8'h00);
    scan_frame("t6b", 32'h0, 8'h01, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
